// File: rtl/slt_pkg.sv
// Shared constants for the set-less-than block: default operand width and
// the encoding of the compare-mode select input.
package slt_pkg;

    localparam int SLT_WIDTH_DEFAULT = 32;

    localparam logic MODE_SIGNED   = 1'b0;
    localparam logic MODE_UNSIGNED = 1'b1;

endpackage

// File: rtl/slt_cmp.sv
// WIDTH-bit subtractor producing both the signed and unsigned less-than flags
// for X - Y. The subtraction is done one bit wider so the borrow is explicit.
module slt_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             lt_s_o,
    output logic             lt_u_o
);

    logic [WIDTH:0]    diff_ext;
    logic signed [WIDTH-1:0] diff;
    logic              ovf;

    // Subtract, then derive two's-complement overflow and borrow-based flags.
    always_comb begin
        diff_ext = {1'b0, x_i} - {1'b0, y_i};
        diff     = $signed(diff_ext[WIDTH-1:0]);
        // Overflow only when operand signs differ and the result sign differs from X.
        ovf      = (x_i[WIDTH-1] ^ y_i[WIDTH-1]) & (x_i[WIDTH-1] ^ diff[WIDTH-1]);
        lt_s_o   = diff[WIDTH-1] ^ ovf;
        lt_u_o   = diff_ext[WIDTH];
    end

endmodule

// File: rtl/slt.sv
// Set-less-than: combinational compare result plus a registered copy with a
// valid flag. Build option SLT_UNSIGNED_EN enables the unsigned_i mode select;
// without it the compare is always signed and unsigned_i is ignored.
module slt
    import slt_pkg::*;
#(
    parameter int WIDTH = SLT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             unsigned_i,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             valid_q
);

    logic             lt_s;
    logic             lt_u;
    logic             lt_sel;
    logic [WIDTH-1:0] result_d;
    logic             valid_d;

    slt_cmp #(.WIDTH(WIDTH)) u_cmp (
        .x_i    (X),
        .y_i    (Y),
        .lt_s_o (lt_s),
        .lt_u_o (lt_u)
    );

`ifdef SLT_UNSIGNED_EN
    // Pick the flag matching the requested compare mode.
    always_comb begin
        lt_sel = (unsigned_i == MODE_UNSIGNED) ? lt_u : lt_s;
    end
`else
    logic unused_mode;
    assign unused_mode = unsigned_i ^ lt_u;

    // Signed-only build: the mode input has no effect.
    always_comb begin
        lt_sel = lt_s;
    end
`endif

    // Zero-extend the one-bit flag; independent of rst.
    always_comb begin
        result    = '0;
        result[0] = lt_sel;
    end

    // Capture on valid input, otherwise hold the result and drop valid.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d = result;
            valid_d  = 1'b1;
        end
    end

    // Output register; asynchronous reset clears any pending capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_slt.sv
// Testbench for slt (WIDTH=32): table-driven combinational checks, a
// scoreboard for the registered path, and hand-written reset/hold sequences.
module tb_slt;

    localparam int W = 32;
`ifdef SLT_UNSIGNED_EN
    localparam bit UEN = 1'b1;
`else
    localparam bit UEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] X, Y;
    logic         unsigned_i;
    logic         in_valid;
    logic [W-1:0] result, result_q;
    logic         valid_q;

    slt #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .X          (X),
        .Y          (Y),
        .unsigned_i (unsigned_i),
        .in_valid   (in_valid),
        .result     (result),
        .result_q   (result_q),
        .valid_q    (valid_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_u;
    } vec_t;

    typedef struct {
        logic [W-1:0] rq;
        logic         v;
    } sb_t;

    vec_t   vecs[14];
    sb_t    sbq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    logic [W-1:0] last_rq;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        logic lt;
        if (u && UEN) lt = (a < b);
        else          lt = ($signed(a) < $signed(b));
        return {{(W-1){1'b0}}, lt};
    endfunction

    // Drive one input set at the falling edge, check result, queue expected register state.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                         input logic v, input logic [W-1:0] exp_comb, input string name);
        sb_t e;
        @(negedge clk);
        X = a; Y = b; unsigned_i = u; in_valid = v;
        #1;
        chk(name, result, exp_comb);
        e.rq = v ? exp_comb : last_rq;
        e.v  = v;
        last_rq = e.rq;
        sbq.push_back(e);
    endtask

    // After the next rising edge, pop the scoreboard and compare the registered outputs.
    task automatic check_reg(input string name);
        sb_t e;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got result_q %h valid_q %b", name, result_q, valid_q);
        end else begin
            e = sbq.pop_front();
            chk({name, "_rq"}, result_q, e.rq);
            chk({name, "_vq"}, {31'b0, valid_q}, {31'b0, e.v});
            n_cmp--;
        end
    endtask

    initial begin
        vecs[0]  = '{32'h1,        32'h2,        32'h1, 32'h1};
        vecs[1]  = '{32'h2,        32'h2,        32'h0, 32'h0};
        vecs[2]  = '{32'h3,        32'h2,        32'h0, 32'h0};
        vecs[3]  = '{32'hFFFFFFFF, 32'h1,        32'h1, 32'h0};
        vecs[4]  = '{32'h1,        32'hFFFFFFFF, 32'h0, 32'h1};
        vecs[5]  = '{32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0};
        vecs[6]  = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h1};
        vecs[7]  = '{32'h80000000, 32'h80000000, 32'h0, 32'h0};
        vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0};
        vecs[9]  = '{32'h0,        32'h0,        32'h0, 32'h0};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        vecs[11] = '{32'h0,        32'h80000000, 32'h0, 32'h1};
        vecs[12] = '{32'h80000000, 32'h0,        32'h1, 32'h0};
        vecs[13] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h1};

        rst = 1'b1; X = '0; Y = '0; unsigned_i = 1'b0; in_valid = 1'b0;
        last_rq = '0;
        #1;
        chk("reset_rq", result_q, 32'h0);
        chk("reset_vq", {31'b0, valid_q}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_hold_rq", result_q, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: every record in both modes, combinational and registered.
        for (int i = 0; i < 14; i++) begin
            for (int m = 0; m < 2; m++) begin
                logic [W-1:0] ex;
                ex = (m == 1 && UEN) ? vecs[i].exp_u : vecs[i].exp_s;
                drive(vecs[i].x, vecs[i].y, m[0], 1'b1, ex, $sformatf("vec%0d_m%0d", i, m));
                check_reg($sformatf("reg%0d_m%0d", i, m));
            end
        end

        // Random traffic with sporadic valid against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic u, v;
            a = $urandom; b = (i % 5 == 0) ? a : $urandom;
            u = $urandom_range(0, 1); v = $urandom_range(0, 1);
            drive(a, b, u, v, model(a, b, u), $sformatf("rnd%0d", i));
            check_reg($sformatf("rndreg%0d", i));
        end

        // Capture 1 < 2, then hold with in_valid low.
        drive(32'h1, 32'h2, 1'b0, 1'b1, 32'h1, "seq_cap");
        check_reg("seq_cap");
        drive(32'h5, 32'h2, 1'b0, 1'b0, 32'h0, "seq_hold");
        check_reg("seq_hold");
        chk("seq_hold_rq1", result_q, 32'h1);

        // Async reset between edges with a capture pending.
        @(negedge clk);
        X = 32'h1; Y = 32'h2; unsigned_i = 1'b0; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_rq", result_q, 32'h0);
        chk("arst_vq", {31'b0, valid_q}, 32'h0);
        chk("arst_comb", result, 32'h1);
        @(posedge clk);
        #1;
        chk("arst_edge_rq", result_q, 32'h0);
        chk("arst_edge_vq", {31'b0, valid_q}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle_vq", {31'b0, valid_q}, 32'h0);
        chk("post_rst_idle_rq", result_q, 32'h0);
        sbq.delete();
        last_rq = '0;
        drive(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h1, "post_rst_cap");
        check_reg("post_rst_cap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/slt.md
SLT -- requirements
Module: slt

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; must be 2 or more.
REQ-002 clk  input  1  sole clock; all registers update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 X  input  WIDTH  first operand (left-hand side of the comparison).
REQ-005 Y  input  WIDTH  second operand (right-hand side of the comparison).
REQ-006 unsigned_i  input  1  compare mode: 0 = signed (SLT), 1 = unsigned (SLTU).
REQ-007 in_valid  input  1  qualifies X/Y/unsigned_i for capture into the registered outputs.
REQ-008 result  output  WIDTH  combinational compare result.
REQ-009 result_q  output  WIDTH  registered copy of result.
REQ-010 valid_q  output  1  result_q holds a fresh result captured on the previous edge.

Function
REQ-011 result SHALL be purely combinational from X, Y and unsigned_i, with zero clock latency.
REQ-012 result SHALL be 1 (LSB set, all upper bits 0) when X < Y under the selected mode, else all zeros.
REQ-013 Signed mode SHALL treat X and Y as two's complement: lt = sign(X-Y) XOR overflow(X-Y).
REQ-014 Unsigned mode SHALL assert lt exactly when the subtraction X-Y borrows.
REQ-015 X == Y SHALL give result 0 in both modes.
REQ-016 Boundary pairs SHALL compare correctly without wrap error, including MIN vs MAX, MAX vs MIN, and any value vs itself.
REQ-017 On a rising clk edge with in_valid=1: result_q <= result and valid_q <= 1.
REQ-018 On a rising clk edge with in_valid=0: valid_q <= 0 and result_q holds its value.
REQ-019 result_q and valid_q SHALL have exactly one clock of latency from the capturing edge.

Reset
REQ-020 While rst=1, result_q SHALL be 0 and valid_q SHALL be 0, immediately and independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard any pending capture.
REQ-022 The first capture after reset deassertion SHALL occur on the first rising edge with in_valid=1.
REQ-023 The combinational result SHALL be unaffected by rst.

Configuration
REQ-024 Macro SLT_UNSIGNED_EN defined: unsigned_i SHALL select the mode as specified in REQ-006.
REQ-025 Macro SLT_UNSIGNED_EN undefined: unsigned_i SHALL remain a port but be ignored, and comparison SHALL always be signed.

Structure
REQ-026 Package slt_pkg SHALL hold the WIDTH default constant and the mode encoding constants (MODE_SIGNED=0, MODE_UNSIGNED=1).
REQ-027 Sub-module slt_cmp SHALL implement the WIDTH-bit subtractor.
REQ-028 slt_cmp SHALL output the signed-lt and unsigned-lt flags.
REQ-029 slt SHALL perform mode selection, zero extension and output registering around slt_cmp.

Verification
REQ-030 X=1, Y=2, signed -> result=0x00000001.
REQ-031 X=2, Y=2, signed -> result=0x00000000. X=3, Y=2, signed -> result=0x00000000.
REQ-032 X=0xFFFFFFFF, Y=1: signed -> result=1; unsigned (SLT_UNSIGNED_EN defined) -> result=0.
REQ-033 X=1, Y=0xFFFFFFFF: signed -> result=0; unsigned -> result=1.
REQ-034 X=0x80000000, Y=0x7FFFFFFF, signed -> result=1; swapped operands -> result=0.
REQ-035 Registered path: in_valid=1 with X=1, Y=2 -> result_q=1 and valid_q=1 after one edge.
REQ-036 Registered path: then in_valid=0 -> valid_q=0 and result_q=1 held.
REQ-037 Registered path: assert rst between edges -> result_q=0 and valid_q=0 at once.
